// File: rtl/dbf_line_sequencer_pkg.sv
// Shared widths and FSM state encoding for the per-line beamformer sequencer.
package dbf_line_sequencer_pkg;
    localparam int ADDR_WD_DEF = 10;
    localparam int CNT_WD_DEF  = 16;
    localparam int LINE_WD_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_TX   = 3'd2,
        ST_RX   = 3'd3,
        ST_GAP  = 3'd4
    } seq_state_e;
endpackage

// File: rtl/dbf_phase_timer.sv
// Loadable down-counter; tc flags the last cycle of a phase (count == 1).
module dbf_phase_timer #(
    parameter int CNT_WD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CNT_WD-1:0] load_val,
    input  logic              en,
    output logic              tc
);
    localparam logic [CNT_WD-1:0] ONE = 1;

    logic [CNT_WD-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - ONE;
    end

    assign tc = (cnt == ONE);
endmodule

// File: rtl/dbf_line_sequencer.sv
// Scan-line controller: LUT load, TX window, RX window with apodisation index, idle gap.
module dbf_line_sequencer
    import dbf_line_sequencer_pkg::*;
#(
    parameter int ADDR_WD = ADDR_WD_DEF,
    parameter int CNT_WD  = CNT_WD_DEF,
    parameter int LINE_WD = LINE_WD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               abort,
    input  logic [LINE_WD-1:0] cfg_num_lines,
    input  logic [ADDR_WD:0]   cfg_lut_depth,
    input  logic [CNT_WD-1:0]  cfg_tx_cycles,
    input  logic [CNT_WD-1:0]  cfg_rx_samples,
    input  logic [CNT_WD-1:0]  cfg_gap,
    input  logic               lut_data_valid,
    output logic               lut_data_ready,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic               dbf_lut_we,
    output logic               tx_en,
    output logic               start,
    output logic [CNT_WD-1:0]  apo_addr,
    output logic [LINE_WD-1:0] line_idx,
    output logic               busy,
    output logic               line_done,
    output logic               frame_done
);
    localparam logic [ADDR_WD:0]   ONE_A = 1;
    localparam logic [CNT_WD-1:0]  ONE_C = 1;
    localparam logic [LINE_WD-1:0] ONE_L = 1;

    seq_state_e state, nxt;

    logic [LINE_WD-1:0] num_lines_q;
    logic [ADDR_WD:0]   depth_q;
    logic [CNT_WD-1:0]  tx_q, rx_q, gap_q;
    logic [ADDR_WD:0]   wcnt;
    logic               ld_q, fd_q;

    logic               t_load, tc;
    logic [CNT_WD-1:0]  t_val;
    logic               latch, set_ld, set_fd, line_end;
    logic               beat, last_beat, last_line, gap_end;

    assign beat      = (state == ST_LOAD) && lut_data_valid && !abort;
    assign last_beat = beat && (wcnt == depth_q - ONE_A);
    assign last_line = (line_idx == num_lines_q - ONE_L);
    assign gap_end   = (state == ST_GAP) && tc && !abort;

    dbf_phase_timer #(.CNT_WD(CNT_WD)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n | abort),
        .load     (t_load),
        .load_val (t_val),
        .en       (state == ST_TX || state == ST_RX || state == ST_GAP),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (rst_n)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt      = state;
        t_load   = 1'b0;
        t_val    = '0;
        latch    = 1'b0;
        set_ld   = 1'b0;
        set_fd   = 1'b0;
        line_end = 1'b0;
        if (abort) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (go) begin
                    latch = 1'b1;
                    if (cfg_num_lines == '0) set_fd = 1'b1;
                    else                     nxt    = ST_LOAD;
                end
                ST_LOAD: if (last_beat) begin
                    nxt    = ST_TX;
                    t_load = 1'b1;
                    t_val  = tx_q;
                end
                ST_TX: if (tc) begin
                    nxt    = ST_RX;
                    t_load = 1'b1;
                    t_val  = rx_q;
                end
                ST_RX: if (tc) begin
                    if (gap_q == '0) begin
                        // no gap: done pulses are registered into the following cycle
                        set_ld   = 1'b1;
                        set_fd   = last_line;
                        line_end = 1'b1;
                        nxt      = last_line ? ST_IDLE : ST_LOAD;
                    end else begin
                        nxt    = ST_GAP;
                        t_load = 1'b1;
                        t_val  = gap_q;
                    end
                end
                ST_GAP: if (tc) begin
                    line_end = 1'b1;
                    nxt      = last_line ? ST_IDLE : ST_LOAD;
                end
                default: nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            num_lines_q  <= '0;
            depth_q      <= ONE_A;
            tx_q         <= ONE_C;
            rx_q         <= ONE_C;
            gap_q        <= '0;
            wcnt         <= '0;
            dbf_lut_we   <= 1'b0;
            dbf_lut_addr <= '0;
            apo_addr     <= '0;
            line_idx     <= '0;
            ld_q         <= 1'b0;
            fd_q         <= 1'b0;
        end else begin
            if (latch) begin
                num_lines_q <= cfg_num_lines;
                depth_q     <= (cfg_lut_depth == '0) ? ONE_A : cfg_lut_depth;
                tx_q        <= (cfg_tx_cycles == '0) ? ONE_C : cfg_tx_cycles;
                rx_q        <= (cfg_rx_samples == '0) ? ONE_C : cfg_rx_samples;
                gap_q       <= cfg_gap;
            end
            dbf_lut_we   <= beat;
            dbf_lut_addr <= beat ? wcnt[ADDR_WD-1:0] : '0;
            if (abort || last_beat) wcnt <= '0;
            else if (beat)          wcnt <= wcnt + ONE_A;
            apo_addr <= (state == ST_RX && !tc && !abort) ? apo_addr + ONE_C : '0;
            if (abort || latch)              line_idx <= '0;
            else if (line_end && !last_line) line_idx <= line_idx + ONE_L;
            ld_q <= set_ld;
            fd_q <= set_fd;
        end
    end

    assign lut_data_ready = (state == ST_LOAD);
    assign tx_en          = (state == ST_TX);
    assign start          = (state == ST_RX);
    assign busy           = (state != ST_IDLE);
    assign line_done      = ld_q | gap_end;
    assign frame_done     = fd_q | (gap_end && last_line);
endmodule

// File: tb/tb_dbf_line_sequencer.sv
// Self-checking bench: per-cycle expected trace built from phase lengths and valid pattern.
module tb_dbf_line_sequencer;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        go = 1'b0, abort = 1'b0;
    logic [7:0]  cfg_num_lines = '0;
    logic [10:0] cfg_lut_depth = '0;
    logic [15:0] cfg_tx_cycles = '0, cfg_rx_samples = '0, cfg_gap = '0;
    logic        lut_data_valid = 1'b0;
    logic        lut_data_ready, dbf_lut_we, tx_en, start, busy, line_done, frame_done;
    logic [9:0]  dbf_lut_addr;
    logic [15:0] apo_addr;
    logic [7:0]  line_idx;

    int checks = 0, errors = 0;

    bit e_tx[MAXC], e_st[MAXC], e_we[MAXC], e_busy[MAXC], e_ld[MAXC], e_fd[MAXC], e_rdy[MAXC];
    int e_apo[MAXC], e_addr[MAXC], e_line[MAXC];
    bit vpat[MAXC];
    int end_c, rx_first;

    always #5 clk = ~clk;

    dbf_line_sequencer dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .cfg_num_lines(cfg_num_lines), .cfg_lut_depth(cfg_lut_depth),
        .cfg_tx_cycles(cfg_tx_cycles), .cfg_rx_samples(cfg_rx_samples), .cfg_gap(cfg_gap),
        .lut_data_valid(lut_data_valid), .lut_data_ready(lut_data_ready),
        .dbf_lut_addr(dbf_lut_addr), .dbf_lut_we(dbf_lut_we), .tx_en(tx_en), .start(start),
        .apo_addr(apo_addr), .line_idx(line_idx), .busy(busy),
        .line_done(line_done), .frame_done(frame_done)
    );

    // Expected trace: cycle k is the k-th cycle after the edge that sampled go.
    task automatic build_model(input int lines, input int depth, input int tx, input int rx, input int gap);
        int c, de, te, re, acc;
        for (int k = 0; k < MAXC; k++) begin
            e_tx[k] = 0; e_st[k] = 0; e_we[k] = 0; e_busy[k] = 0; e_ld[k] = 0;
            e_fd[k] = 0; e_rdy[k] = 0; e_apo[k] = 0; e_addr[k] = 0; e_line[k] = 0;
        end
        de = (depth == 0) ? 1 : depth;
        te = (tx == 0) ? 1 : tx;
        re = (rx == 0) ? 1 : rx;
        rx_first = 0;
        c = 1;
        if (lines == 0) begin
            e_fd[1] = 1;
            end_c = 2;
            return;
        end
        for (int l = 0; l < lines; l++) begin
            acc = 0;
            while (acc < de && c < MAXC - 64) begin
                e_rdy[c] = 1; e_busy[c] = 1; e_line[c] = l;
                if (vpat[c]) begin
                    e_we[c+1] = 1; e_addr[c+1] = acc; acc++;
                end
                c++;
            end
            for (int i = 0; i < te; i++) begin
                e_tx[c] = 1; e_busy[c] = 1; e_line[c] = l; c++;
            end
            for (int i = 0; i < re; i++) begin
                if (l == 0 && i == 0) rx_first = c;
                e_st[c] = 1; e_apo[c] = i; e_busy[c] = 1; e_line[c] = l; c++;
            end
            if (gap == 0) begin
                e_ld[c] = 1; e_line[c] = l;
                if (l == lines - 1) e_fd[c] = 1;
            end else begin
                for (int i = 0; i < gap; i++) begin
                    e_busy[c] = 1; e_line[c] = l;
                    if (i == gap - 1) begin
                        e_ld[c] = 1;
                        if (l == lines - 1) e_fd[c] = 1;
                    end
                    c++;
                end
            end
        end
        for (int k = c; k < MAXC; k++) e_line[k] = lines - 1;
        end_c = c;
    endtask

    // stop_kind: 0 none, 1 abort during stop_at, 2 reset during stop_at.
    task automatic run_frame(input string name, input int lines, input int depth, input int tx,
                             input int rx, input int gap, input int stop_at, input int stop_kind,
                             input bit noise);
        int ncyc;
        logic [40:0] act, exp;
        build_model(lines, depth, tx, rx, gap);
        ncyc = end_c + 3;
        if (stop_kind != 0) begin
            for (int k = stop_at + 1; k < MAXC; k++) begin
                e_tx[k] = 0; e_st[k] = 0; e_we[k] = 0; e_busy[k] = 0; e_ld[k] = 0;
                e_fd[k] = 0; e_rdy[k] = 0; e_apo[k] = 0; e_addr[k] = 0; e_line[k] = 0;
            end
            ncyc = stop_at + 4;
        end
        cfg_num_lines  = 8'(lines);
        cfg_lut_depth  = 11'(depth);
        cfg_tx_cycles  = 16'(tx);
        cfg_rx_samples = 16'(rx);
        cfg_gap        = 16'(gap);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            lut_data_valid = vpat[k];
            if (noise) begin
                cfg_num_lines  = 8'($urandom_range(0, 5));
                cfg_lut_depth  = 11'($urandom_range(0, 20));
                cfg_tx_cycles  = 16'($urandom_range(0, 9));
                cfg_rx_samples = 16'($urandom_range(0, 9));
                cfg_gap        = 16'($urandom_range(0, 9));
                go = e_busy[k] && ($urandom_range(0, 3) == 0);
            end
            abort = (stop_kind == 1 && k == stop_at);
            if (stop_kind == 2 && k == stop_at) rst_n = 1'b1;
            if (stop_kind == 2 && k == stop_at + 1) rst_n = 1'b0;
            @(negedge clk);
            act = {tx_en, start, apo_addr, dbf_lut_we, (e_we[k] ? dbf_lut_addr : 10'd0),
                   busy, line_done, frame_done, lut_data_ready, line_idx};
            exp = {e_tx[k], e_st[k], 16'(e_apo[k]), e_we[k], 10'(e_addr[k]),
                   e_busy[k], e_ld[k], e_fd[k], e_rdy[k], 8'(e_line[k])};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s cyc %0d got tx=%b st=%b apo=%0d we=%b addr=%0d busy=%b ld=%b fd=%b rdy=%b line=%0d | exp tx=%b st=%b apo=%0d we=%b addr=%0d busy=%b ld=%b fd=%b rdy=%b line=%0d",
                         name, k, tx_en, start, apo_addr, dbf_lut_we, dbf_lut_addr, busy, line_done,
                         frame_done, lut_data_ready, line_idx, e_tx[k], e_st[k], e_apo[k], e_we[k],
                         e_addr[k], e_busy[k], e_ld[k], e_fd[k], e_rdy[k], e_line[k]);
            end
            @(posedge clk); #1;
        end
        go = 1'b0; abort = 1'b0; rst_n = 1'b0; lut_data_valid = 1'b0;
    endtask

    task automatic fill_valid(input int mode);
        for (int k = 0; k < MAXC; k++)
            vpat[k] = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tx_en, start, apo_addr, dbf_lut_we, dbf_lut_addr, busy, line_done, frame_done,
             lut_data_ready, line_idx} !== 41'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b tx=%b st=%b we=%b line=%0d required all zero",
                     busy, tx_en, start, dbf_lut_we, line_idx);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        fill_valid(0);
        run_frame("basic", 2, 4, 3, 5, 2, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        fill_valid(0);
        for (int k = 0; k < 7; k++) vpat[k+1] = pat[k];
        run_frame("backpressure", 1, 4, 2, 2, 1, 0, 0, 1'b0);
    endtask

    task automatic test_zero_configs();
        fill_valid(0);
        run_frame("zero_lines", 0, 4, 3, 3, 3, 0, 0, 1'b0);
        run_frame("zero_txrx", 2, 2, 0, 0, 1, 0, 0, 1'b0);
        run_frame("zero_gap", 3, 3, 2, 3, 0, 0, 0, 1'b0);
        run_frame("zero_depth", 1, 0, 1, 1, 0, 0, 0, 1'b0);
    endtask

    task automatic test_abort();
        fill_valid(0);
        build_model(2, 4, 3, 5, 2);
        run_frame("abort_rx", 2, 4, 3, 5, 2, rx_first + 2, 1, 1'b0);
        run_frame("after_abort", 2, 4, 3, 5, 2, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        fill_valid(0);
        run_frame("reset_load", 1, 8, 2, 2, 2, 3, 2, 1'b0);
    endtask

    task automatic test_go_abort_idle();
        cfg_num_lines = 8'd1; cfg_lut_depth = 11'd2;
        go = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({busy, lut_data_ready, frame_done, line_done} !== 4'b0000) begin
                errors++;
                $display("FAIL go_abort_idle cyc %0d got busy=%b rdy=%b fd=%b ld=%b required 0",
                         k, busy, lut_data_ready, frame_done, line_done);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            fill_valid(1);
            run_frame("random", $urandom_range(1, 4), $urandom_range(0, 12), $urandom_range(0, 6),
                      $urandom_range(0, 6), $urandom_range(0, 4), 0, 0, (n % 2) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_configs();
        test_abort();
        test_reset_mid_load();
        test_go_abort_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dbf_line_sequencer.md
Name: dbf_line_sequencer

Overview:
- Per-scan-line controller for the bank of dbf_chNN channel datapaths.
- For each line it runs four phases in order:
  1. Streams coarse/fine delay LUT contents into the channels through the shared dbf_lut_addr/dbf_lut_we bus.
  2. Drives the transmit window (tx_en).
  3. Drives the receive/beamform window (start), and generates the apodisation-table read address.
  4. Inserts a configurable idle gap.
- Repeats for a programmed number of lines per frame. Sits between the host/config interface and all channel instances.

Parameters:
- ADDR_WD, 10, width of LUT address bus (matches channel dbf_lut_addr).
- CNT_WD, 16, width of tx/rx/gap cycle counters and config fields.
- LINE_WD, 8, width of line counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-high reset (asserted = 1, sampled on rising clk; the port name is kept for consistency with the channel modules).
- go  in  1  single-cycle frame start request; ignored unless idle.
- abort  in  1  synchronous abort; returns the block to idle.
- cfg_num_lines  in  LINE_WD  lines per frame.
- cfg_lut_depth  in  ADDR_WD+1  LUT words per line (1..2^ADDR_WD).
- cfg_tx_cycles  in  CNT_WD  tx_en high time.
- cfg_rx_samples  in  CNT_WD  start high time.
- cfg_gap  in  CNT_WD  idle cycles after rx.
- lut_data_valid  in  1  host LUT word available (data itself is routed to the channels externally).
- lut_data_ready  out  1  sequencer accepts a LUT word.
- dbf_lut_addr  out  ADDR_WD  LUT write address to the channels.
- dbf_lut_we  out  1  LUT write enable to the channels.
- tx_en  out  1  transmit window.
- start  out  1  receive/beamform window.
- apo_addr  out  CNT_WD  apodisation table index, valid while start=1.
- line_idx  out  LINE_WD  current line number.
- busy  out  1  high in any state other than IDLE.
- line_done  out  1  one-cycle pulse at the end of each line.
- frame_done  out  1  one-cycle pulse at the end of the frame.

Behaviour:
- Reset or abort: all outputs are 0 and the FSM goes to IDLE on the next edge. Reset has priority over abort; abort has priority over all other transitions. An abort produces no line_done or frame_done pulse.
- States: IDLE, LOAD, TX, RX, GAP.
- IDLE:
  - On go, latch all cfg_* fields (config changes during a frame are ignored) and set line_idx=0.
  - If cfg_num_lines==0, pulse frame_done on the next cycle and stay in IDLE.
  - Otherwise enter LOAD on the next cycle.
- LOAD:
  - lut_data_ready=1 (combinational from state).
  - Each beat with valid&ready registers dbf_lut_we=1 and dbf_lut_addr=word count on the next cycle; addresses run 0..cfg_lut_depth-1.
  - Without valid, no write occurs and the count holds.
  - After the cfg_lut_depth-th accepted beat, go to TX. The last write appears on the bus in the first TX cycle.
  - cfg_lut_depth==0 is treated as 1.
- TX: tx_en=1 for exactly max(cfg_tx_cycles,1) cycles, then RX.
- RX:
  - start=1 for exactly max(cfg_rx_samples,1) cycles.
  - apo_addr is 0 on the first start cycle and increments by 1 each cycle; it returns to 0 when RX ends.
  - start and tx_en are never both high.
- GAP:
  - Lasts cfg_gap cycles; 0 means it is skipped.
  - line_done pulses in the last GAP cycle, or in the cycle after the last RX cycle when cfg_gap==0.
  - If line_idx==num_lines-1: frame_done pulses in the same cycle as line_done, then IDLE.
  - Otherwise line_idx increments and the FSM enters LOAD.
- Simultaneous go and abort in IDLE: abort wins and the block stays idle.
- go while busy: ignored.
- The address counter wraps to 0 only by reset between lines; it never exceeds cfg_lut_depth-1.

Decomposition:
- Shared package (param.h): ADDR_WD, CNT_WD, LINE_WD defaults, and state encodings (IDLE=0, LOAD=1, TX=2, RX=3, GAP=4).
- One natural sub-module: dbf_phase_timer. It is a loadable down-counter with load value, enable and a terminal-count flag, and is reused for the TX, RX and GAP durations.

Test Plan:
- Basic frame (lines=2, depth=4, tx=3, rx=5, gap=2, valid held high):
  - lut_we addresses 0,1,2,3 per line.
  - tx_en high for 3 cycles, start high for 5 cycles with apo_addr 0..4.
  - line_done twice; frame_done coincides with the second line_done; busy is 0 afterwards.
- Backpressure (depth=4, valid toggled 1,0,0,1,1,0,1): exactly 4 writes at addresses 0..3; TX begins only after the 4th accepted beat.
- Zero-length configs:
  - lines=0 → frame_done one cycle after go, busy stays 0.
  - tx=0 and rx=0 → each window lasts 1 cycle.
  - gap=0 → line_done in the cycle after the last start cycle.
- Abort in RX at the 3rd cycle:
  - Next cycle: start=0, busy=0, apo_addr=0, no done pulses.
  - A following go restarts from line 0.
- Reset asserted mid-LOAD after 2 writes: all outputs are 0 on the next edge and no further writes occur.
- go while busy, and cfg changes mid-frame: no effect on timing; the latched values are used.
